regfile_dump_tx: RTL and testbench
==================================

// Module: regfile_dump_tx
// PURPOSE
//   Read-side initiator for the 8x16 register file. On a start pulse it walks
//   an address window through one regfile read port and streams each word out
//   over a valid/ready handshake, tagged with its address. Sits between the
//   register file and a debug/UART transmit path.
// PARAMETERS
//   DATA_W  16  width of a register word / out_data
//   ADDR_W  3   register address width (NREGS = 2**ADDR_W = 8)
// PORTS
//   clk         in   1       clock, all state on rising edge
//   reset       in   1       synchronous, active-high
//   start       in   1       begin dump; sampled only in IDLE
//   first_addr  in   ADDR_W  first register of window, sampled with start
//   last_addr   in   ADDR_W  last register of window, sampled with start
//   rd_addr     out  ADDR_W  to regfile read-port address
//   rd_data     in   DATA_W  from regfile read port (combinational, same cycle)
//   out_valid   out  1       out_data/out_addr/out_last valid
//   out_ready   in   1       sink accepts when out_valid & out_ready
//   out_data    out  DATA_W  registered word
//   out_addr    out  ADDR_W  source register of out_data
//   out_last    out  1       final word of this dump
//   busy        out  1       high in every state except IDLE
//   done        out  1       one-cycle pulse after final word accepted
// BEHAVIOUR
//   - Reset: state=IDLE; out_valid, out_last, busy, done = 0; out_data=0;
//     out_addr=0; rd_addr=0; ptr=0; sum=0. Reset mid-dump aborts immediately;
//     any un-accepted word is dropped.
//   - FSM: IDLE -> LOAD -> SEND -> (LOAD | CSUM | DONE) -> IDLE.
//   - IDLE: start=1 -> latch ptr=first_addr, end=last_addr, sum=0; go LOAD.
//   - LOAD (1 cycle): rd_addr=ptr; at edge capture out_data=rd_data,
//     out_addr=ptr, out_last=(ptr==end && no CSUM), out_valid=1; go SEND.
//   - SEND: out_valid held, out_* stable until handshake. On out_valid&out_ready:
//     sum+=out_data (mod 2**DATA_W); if ptr==end go CSUM (if enabled) else DONE;
//     otherwise ptr=ptr+1 (wraps 7->0), go LOAD. out_valid drops the same edge.
//   - DONE: done=1 for exactly one cycle, busy still 1; next cycle IDLE.
//   - Latency: start at cycle N -> out_valid at N+2. Max rate 1 word/2 cycles.
//   - Window: count = ((last_addr - first_addr) mod 8) + 1; first==last -> 1
//     word; first>last wraps through 7->0 (e.g. 6..1 = 6,7,0,1).
//   - start while busy: ignored, no effect on the current dump.
//   - Word content is the regfile value during its LOAD cycle; concurrent
//     regfile writes to already-read addresses are not reflected.
//   - rd_addr is driven to ptr in every state (stable, glitch-free register).
// CONFIGURATION
//   REGFILE_DUMP_CSUM_EN defined: after the last data word, state CSUM
//     presents one extra word out_data=sum, out_addr=0, out_last=1 (data
//     words all have out_last=0); handshake identical to SEND; then DONE.
//   Undefined: no CSUM state; out_last=1 on the final data word.
// STRUCTURE
//   Shared package/header: state encodings (IDLE, LOAD, SEND, CSUM, DONE),
//   DATA_W/ADDR_W defaults, NREGS. Single flat module; no sub-module needed.
// TESTING
//   1 Regs r0..r7 = 16'h1000+i; start, first=0,last=7, ready=1 -> 8 words
//     addr 0..7, data 16'h1000..16'h1007, out_last only on addr 7, done once.
//   2 first=6,last=1 -> words from addr 6,7,0,1 in that order; 4 words total.
//   3 first=last=3, ready held low 10 cycles -> valid held, data 16'h1003
//     stable throughout; accepted on ready rise; done next cycle.
//   4 start pulsed again mid-dump (first=0,last=0) -> ignored; original
//     window completes unchanged.
//   5 reset asserted while SEND pending -> next cycle out_valid=0, busy=0;
//     subsequent start runs a clean full dump.
//   6 CSUM_EN, regs 16'hFFFF,16'h0002 (first=0,last=1) -> 3rd word
//     16'h0001, out_addr=0, out_last=1; data words have out_last=0.

Source files
------------

// File: rtl/regfile_dump_tx_pkg.sv
// Shared definitions for the register-file dump initiator.
//   DATA_W / ADDR_W : default word and address widths of the 8x16 regfile
//   NREGS           : number of registers addressed by ADDR_W
//   state_e         : dump FSM state encoding (IDLE, LOAD, SEND, CSUM, DONE)
package regfile_dump_tx_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_dump_tx.sv
// regfile_dump_tx: on a start pulse, walks the address window
// first_addr..last_addr (wrapping 7->0) through one regfile read port and
// streams each word out tagged with its source address.
//
// Optional feature macro: REGFILE_DUMP_CSUM_EN -- appends one checksum word
// (sum of data words mod 2**DATA_W, out_addr=0, out_last=1) after the data.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start               begin dump (sampled only in IDLE)
//   first_addr/last_addr window bounds, sampled with start
//   rd_addr / rd_data   regfile read port (rd_data combinational)
//   out_valid/out_ready output handshake
//   out_data/out_addr/out_last  registered output word and tags
//   busy                high in every state except IDLE
//   done                one-cycle pulse after the final word is accepted
//   dbg_state           current FSM state
//
// Handshake: a word transfers on a rising edge where out_valid & out_ready;
// once out_valid is high, out_data/out_addr/out_last hold until that transfer.
module regfile_dump_tx
  import regfile_dump_tx_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output state_e        dbg_state
);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] end_q, end_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic          out_last_q, out_last_d;
  logic          out_valid_q, out_valid_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      end_q       <= '0;
      sum_q       <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      end_q       <= end_d;
      sum_q       <= sum_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    end_d       = end_q;
    sum_d       = sum_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d   = first_addr;
          end_d   = last_addr;
          sum_d   = '0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        out_data_d  = rd_data;
        out_addr_d  = ptr_q;
        out_valid_d = 1'b1;
`ifdef REGFILE_DUMP_CSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (ptr_q == end_q);
`endif
        state_d     = ST_SEND;
      end

      ST_SEND: begin
        if (out_ready) begin
          sum_d       = sum_q + out_data_q;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (ptr_q == end_q) begin
`ifdef REGFILE_DUMP_CSUM_EN
            // Checksum word is loaded on the same edge that accepts the last
            // data word, so it already includes that word.
            out_data_d  = sum_q + out_data_q;
            out_addr_d  = '0;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            state_d     = ST_CSUM;
`else
            state_d     = ST_DONE;
`endif
          end else begin
            ptr_d   = ptr_q + AW'(1);
            state_d = ST_LOAD;
          end
        end
      end

      ST_CSUM: begin
`ifdef REGFILE_DUMP_CSUM_EN
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_addr   = ptr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Bench for regfile_dump_tx: a small regfile model feeds rd_data; each start
// pushes the expected word stream into exp_q, and a monitor pops and compares
// on every accepted word.
module tb_regfile_dump_tx;
  import regfile_dump_tx_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  first_addr, last_addr;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_addr;
  logic        out_last, busy, done;
  state_e      dbg_state;

  logic [15:0] regs [0:7];
  logic [19:0] exp_q [$];   // {addr, data, last}
  int          checks   = 0;
  int          failures = 0;
  int          done_cnt = 0;

`ifdef REGFILE_DUMP_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  regfile_dump_tx dut (
    .clk(clk), .reset(reset), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: inputs change just after posedge, so the negedge sees the values
  // that the next posedge will act on.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %h expected none", {out_addr, out_data, out_last});
        end else begin
          check("word", {12'd0, out_addr, out_data, out_last}, {12'd0, exp_q.pop_front()});
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the expected stream for a window, then pulse start for one cycle.
  task automatic issue_start(input logic [2:0] f, input logic [2:0] l);
    int          n;
    logic [2:0]  a;
    logic [15:0] s;
    n = int'(3'(l - f)) + 1;
    a = f;
    s = '0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a, regs[a], (i == n - 1) && !CSUM});
      s = s + regs[a];
      a = a + 3'd1;
    end
    if (CSUM) exp_q.push_back({3'd0, s, 1'b1});
    done_cnt   = 0;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      if (done) seen = 1;
      else tick();
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    tick();
    check({name, "_done_pulse_once"}, 32'(done_cnt), 32'd1);
    check({name, "_done_low_after"}, 32'(done), 32'd0);
    check({name, "_idle_after"}, 32'(busy), 32'd0);
    check({name, "_all_words_seen"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) regs[i] = 16'h1000 + 16'(i);
    repeat (3) tick();

    // Reset values
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    reset = 1'b0;
    tick();

    // 1: full window 0..7 with latency check (start in cycle N, valid at N+2)
    issue_start(3'd0, 3'd7);
    check("t1_valid_n1", 32'(out_valid), 32'd0);
    check("t1_busy_n1", 32'(busy), 32'd1);
    tick();
    check("t1_valid_n2", 32'(out_valid), 32'd1);
    wait_done("t1", 100);

    // 2: wrapping window 6..1
    issue_start(3'd6, 3'd1);
    wait_done("t2", 100);

    // 3: single word with back-pressure
    out_ready = 1'b0;
    issue_start(3'd3, 3'd3);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t3_valid_held", 32'(out_valid), 32'd1);
      check("t3_data_stable", 32'(out_data), 32'h1003);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t3_done_next", 32'(done), 32'd1);
    wait_done("t3", 10);

    // 4: start mid-dump is ignored
    issue_start(3'd2, 3'd5);
    repeat (3) tick();
    check("t4_busy_mid", 32'(busy), 32'd1);
    first_addr = 3'd0; last_addr = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4", 100);

    // 5: reset while a word is pending, then a clean dump
    out_ready = 1'b0;
    issue_start(3'd0, 3'd7);
    repeat (3) tick();
    check("t5_pending", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    tick();
    issue_start(3'd0, 3'd7);
    wait_done("t5", 100);

    // 6: checksum wrap case (0xFFFF + 0x0002 = 0x0001)
    regs[0] = 16'hFFFF;
    regs[1] = 16'h0002;
    issue_start(3'd0, 3'd1);
    wait_done("t6", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
